// File: rtl/decode_inst_queue_if.sv
// Fetch-to-decode instruction queue bundle: enqueue side, issue slots, dequeue count.
// Latency: none, this is wiring only.
// Backpressure: in_ready from the queue; decode acknowledges with deq_cnt.
//
// master : fetch/decode side (drives enqueue, flush and deq_cnt)
// slave  : queue side (drives in_ready, out_* slots and count)
interface decode_inst_queue_if #(
    parameter int DEPTH   = 8,
    parameter int ISSUE_W = 2
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DQ_W  = $clog2(ISSUE_W + 1);

    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_pc;
    logic [31:0]            in_inst;
    logic [7:0]             in_excode;
    logic [ISSUE_W-1:0]     out_valid;
    logic [32*ISSUE_W-1:0]  out_pc;
    logic [32*ISSUE_W-1:0]  out_inst;
    logic [8*ISSUE_W-1:0]   out_excode;
    logic [ISSUE_W-1:0]     out_in_slot;
    logic [ISSUE_W-1:0]     out_is_branch;
    logic [DQ_W-1:0]        deq_cnt;
    logic [CNT_W-1:0]       count;

    modport master (
        output flush, in_valid, in_pc, in_inst, in_excode, deq_cnt,
        input  in_ready, out_valid, out_pc, out_inst, out_excode,
               out_in_slot, out_is_branch, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, in_excode, deq_cnt,
        output in_ready, out_valid, out_pc, out_inst, out_excode,
               out_in_slot, out_is_branch, count
    );
endinterface

// File: rtl/decode_inst_queue.sv
// Instruction queue between fetch and decode with branch predecode and delay-slot tagging.
// Latency: an entry written on edge N is visible in slot 0 after edge N (no bypass).
// Backpressure: in_ready = (count != DEPTH); decode consumes up to ISSUE_W per cycle via deq_cnt.
//
// Ports: clk, resetn (async active-low), q (slave modport): flush, in_valid/in_ready,
// in_pc/in_inst/in_excode, out_valid/out_pc/out_inst/out_excode/out_in_slot/
// out_is_branch per slot (slot 0 oldest), deq_cnt, count.
module decode_inst_queue #(
    parameter int DEPTH   = 8,
    parameter int ISSUE_W = 2,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                resetn,
    decode_inst_queue_if.slave  q
);
    localparam int AW   = $clog2(DEPTH);
    localparam int DQ_W = $clog2(ISSUE_W + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [7:0]  excode;
        logic        is_branch;
        logic        in_slot;
    } entry_t;

    // Branch/jump predecode on the MIPS opcode fields.
    function automatic logic predecode_branch(input logic [5:0] op,
                                              input logic [4:0] rt,
                                              input logic [5:0] funct);
        logic br;
        case (op)
            6'b000000: br = (funct == 6'b001000) || (funct == 6'b001001);
            6'b000001: br = (rt == 5'b00000) || (rt == 5'b00001) ||
                            (rt == 5'b10000) || (rt == 5'b10001);
            6'b000010, 6'b000011, 6'b000100,
            6'b000101, 6'b000110, 6'b000111: br = 1'b1;
            default:   br = 1'b0;
        endcase
        return br;
    endfunction

    entry_t             mem [DEPTH];
    logic [AW-1:0]      head;
    logic [AW-1:0]      tail;
    logic [CNT_W-1:0]   count_r;
    logic               last_br;

    logic               in_ready;
    logic               enq;
    logic               in_br;
    entry_t             new_entry;
    logic [ISSUE_W-1:0] slot_vld;
    logic [DQ_W-1:0]    avail;
    logic [DQ_W-1:0]    eff;

    logic [32*ISSUE_W-1:0] slot_pc;
    logic [32*ISSUE_W-1:0] slot_inst;
    logic [8*ISSUE_W-1:0]  slot_excode;
    logic [ISSUE_W-1:0]    slot_in_slot;
    logic [ISSUE_W-1:0]    slot_is_branch;

    // Full/empty come from the count alone; the pointers just wrap.
    assign in_ready = (count_r != CNT_W'(DEPTH));
    assign enq      = q.in_valid && in_ready;
    assign in_br    = predecode_branch(q.in_inst[31:26], q.in_inst[20:16], q.in_inst[5:0]);

    assign new_entry = '{pc:        q.in_pc,
                         inst:      q.in_inst,
                         excode:    q.in_excode,
                         is_branch: in_br,
                         in_slot:   last_br};

    // Issue slots read combinationally from head, head+1, ...
    for (genvar i = 0; i < ISSUE_W; i++) begin : g_slot
        logic [AW-1:0] idx;
        entry_t        e;
        assign idx = head + AW'(i);
        assign e   = mem[idx];
        if (i == 0) begin : g_first
            assign slot_vld[i] = (count_r != '0);
        end else begin : g_rest
            // A branch only issues from slot 0, so it is never split from its delay slot.
            assign slot_vld[i] = (count_r >= CNT_W'(i + 1)) && !e.is_branch;
        end
        assign slot_pc[32*i +: 32]    = slot_vld[i] ? e.pc     : 32'd0;
        assign slot_inst[32*i +: 32]  = slot_vld[i] ? e.inst   : 32'd0;
        assign slot_excode[8*i +: 8]  = slot_vld[i] ? e.excode : 8'd0;
        assign slot_in_slot[i]        = slot_vld[i] && e.in_slot;
        assign slot_is_branch[i]      = slot_vld[i] && e.is_branch;
    end

    // Decode may ask for more than is valid; clamp to the valid slot count.
    always_comb begin
        avail = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            avail = avail + DQ_W'(slot_vld[i]);
        end
        eff = (q.deq_cnt < avail) ? q.deq_cnt : avail;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head    <= '0;
            tail    <= '0;
            count_r <= '0;
            last_br <= 1'b0;
        end else if (q.flush) begin
            head    <= '0;
            tail    <= '0;
            count_r <= '0;
            last_br <= 1'b0;
        end else begin
            if (enq) begin
                tail    <= tail + AW'(1);
                last_br <= in_br;
            end
            head    <= head + AW'(eff);
            count_r <= count_r + CNT_W'(enq) - CNT_W'(eff);
        end
    end

    // Storage needs no reset: every read is qualified by count.
    always_ff @(posedge clk) begin
        if (enq && !q.flush) begin
            mem[tail] <= new_entry;
        end
    end

    assign q.in_ready      = in_ready;
    assign q.count         = count_r;
    assign q.out_valid     = slot_vld;
    assign q.out_pc        = slot_pc;
    assign q.out_inst      = slot_inst;
    assign q.out_excode    = slot_excode;
    assign q.out_in_slot   = slot_in_slot;
    assign q.out_is_branch = slot_is_branch;
endmodule

// File: tb/tb_decode_inst_queue.sv
// Bench for decode_inst_queue (DEPTH=8, ISSUE_W=2): scoreboard of expected entries
// plus per-scenario inline checks.
module tb_decode_inst_queue;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    decode_inst_queue_if #(.DEPTH(8), .ISSUE_W(2)) qi ();
    decode_inst_queue #(.DEPTH(8), .ISSUE_W(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .q      (qi)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [7:0]  exc;
        logic        br;
        logic        slot;
    } sb_t;

    sb_t sb[$];
    bit  last_br = 1'b0;
    int  n_tests = 0;
    int  n_fail  = 0;

    // Reference predecode written from the opcode table.
    function automatic bit m_br(input logic [31:0] w);
        case (w[31:26])
            6'h00:   return (w[5:0] == 6'h08) || (w[5:0] == 6'h09);
            6'h01:   return (w[19:17] == 3'b000);
            6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: checks slots being consumed against the scoreboard, drives inputs,
    // advances the model, then checks count/in_ready.
    task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [7:0] exc, input int dq, input bit fl);
        int  avail, eff;
        bit  mv0, mv1, enq;
        sb_t e;
        mv0   = (sb.size() >= 1);
        mv1   = (sb.size() >= 2) && !sb[1].br;
        avail = int'(mv0) + int'(mv1);
        eff   = (dq < avail) ? dq : avail;
        n_tests++;
        if (qi.out_valid !== {mv1, mv0}) begin
            n_fail++;
            $display("FAIL out_valid: got %b want %b", qi.out_valid, {mv1, mv0});
        end
        if (!fl) begin
            for (int k = 0; k < eff; k++) begin
                n_tests++;
                if (qi.out_pc[32*k +: 32] !== sb[k].pc || qi.out_inst[32*k +: 32] !== sb[k].inst ||
                    qi.out_excode[8*k +: 8] !== sb[k].exc || qi.out_is_branch[k] !== sb[k].br ||
                    qi.out_in_slot[k] !== sb[k].slot) begin
                    n_fail++;
                    $display("FAIL slot%0d: got pc=%h inst=%h exc=%h br=%b ds=%b want pc=%h inst=%h exc=%h br=%b ds=%b",
                             k, qi.out_pc[32*k +: 32], qi.out_inst[32*k +: 32], qi.out_excode[8*k +: 8],
                             qi.out_is_branch[k], qi.out_in_slot[k],
                             sb[k].pc, sb[k].inst, sb[k].exc, sb[k].br, sb[k].slot);
                end
            end
        end
        enq = v && (sb.size() < 8) && !fl;
        qi.in_valid  = v;
        qi.in_pc     = pc;
        qi.in_inst   = inst;
        qi.in_excode = exc;
        qi.deq_cnt   = 2'(dq);
        qi.flush     = fl;
        @(posedge clk);
        if (fl) begin
            sb.delete();
            last_br = 1'b0;
        end else begin
            repeat (eff) void'(sb.pop_front());
            if (enq) begin
                e = '{pc: pc, inst: inst, exc: exc, br: m_br(inst), slot: last_br};
                sb.push_back(e);
                last_br = e.br;
            end
        end
        @(negedge clk);
        qi.in_valid = 1'b0;
        qi.deq_cnt  = '0;
        qi.flush    = 1'b0;
        n_tests++;
        if (qi.count !== 4'(sb.size()) || qi.in_ready !== (sb.size() != 8)) begin
            n_fail++;
            $display("FAIL count/in_ready: got %0d/%b want %0d/%b",
                     qi.count, qi.in_ready, sb.size(), sb.size() != 8);
        end
    endtask

    task automatic test_reset();
        qi.in_valid = 0; qi.in_pc = 0; qi.in_inst = 0; qi.in_excode = 0;
        qi.deq_cnt = 0; qi.flush = 0;
        resetn = 1'b0;
        #12;
        n_tests++;
        if (qi.count !== 4'd0 || qi.in_ready !== 1'b1 || qi.out_valid !== 2'b00 ||
            qi.out_pc !== 64'd0 || qi.out_inst !== 64'd0) begin
            n_fail++;
            $display("FAIL reset: got count=%0d rdy=%b vld=%b pc=%h want 0/1/00/0",
                     qi.count, qi.in_ready, qi.out_valid, qi.out_pc);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        cycle(1, 32'hBFC0_0000, 32'h3C08_0001, 8'h00, 0, 0);
        n_tests++;
        if (qi.out_valid !== 2'b01 || qi.out_pc[31:0] !== 32'hBFC0_0000 || qi.out_is_branch !== 2'b00 ||
            qi.out_in_slot !== 2'b00 || qi.count !== 4'd1) begin
            n_fail++;
            $display("FAIL single: got vld=%b pc=%h br=%b ds=%b cnt=%0d want 01 bfc00000 00 00 1",
                     qi.out_valid, qi.out_pc[31:0], qi.out_is_branch, qi.out_in_slot, qi.count);
        end
        cycle(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_branch_pair();
        cycle(1, 32'hBFC0_0000, 32'h1000_0003, 8'h00, 0, 0);
        cycle(1, 32'hBFC0_0004, 32'h2442_0001, 8'h00, 0, 0);
        n_tests++;
        if (qi.out_valid !== 2'b11 || qi.out_is_branch !== 2'b01 || qi.out_in_slot !== 2'b10) begin
            n_fail++;
            $display("FAIL branch_pair: got vld=%b br=%b ds=%b want 11 01 10",
                     qi.out_valid, qi.out_is_branch, qi.out_in_slot);
        end
        cycle(0, 0, 0, 0, 2, 0);
        n_tests++;
        if (qi.count !== 4'd0) begin
            n_fail++;
            $display("FAIL branch_pair_drain: got count=%0d want 0", qi.count);
        end
    endtask

    task automatic test_jr_block();
        cycle(1, 32'h0000_0100, 32'h0085_1021, 8'h11, 0, 0);
        cycle(1, 32'h0000_0104, 32'h03E0_0008, 8'h22, 0, 0);
        n_tests++;
        if (qi.out_valid !== 2'b01) begin
            n_fail++;
            $display("FAIL jr_block: got vld=%b want 01", qi.out_valid);
        end
        cycle(0, 0, 0, 0, 2, 0);
        n_tests++;
        if (qi.count !== 4'd1 || qi.out_valid[0] !== 1'b1 || qi.out_inst[31:0] !== 32'h03E0_0008 ||
            qi.out_is_branch[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL jr_head: got cnt=%0d vld=%b inst=%h br=%b want 1 x1 03e00008 1",
                     qi.count, qi.out_valid, qi.out_inst[31:0], qi.out_is_branch[0]);
        end
        cycle(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_full_wrap();
        logic [31:0] pc = 32'h0000_1000;
        bit acc;
        for (int i = 0; i < 8; i++) begin
            cycle(1, pc, 32'h2442_0001, 8'(i), 0, 0);
            pc += 4;
        end
        n_tests++;
        if (qi.count !== 4'd8 || qi.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full: got cnt=%0d rdy=%b want 8 0", qi.count, qi.in_ready);
        end
        cycle(1, 32'hDEAD_0000, 32'h2442_0001, 8'hFF, 0, 0);
        n_tests++;
        if (qi.count !== 4'd8 || qi.out_pc[31:0] !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL full_reject: got cnt=%0d pc0=%h want 8 00001000", qi.count, qi.out_pc[31:0]);
        end
        for (int i = 0; i < 20; i++) begin
            acc = (sb.size() < 8);
            cycle(1, pc, 32'h2442_0001, 8'(i + 8), 2, 0);
            if (acc) pc += 4;
        end
        while (sb.size() != 0) cycle(0, 0, 0, 0, 2, 0);
    endtask

    task automatic test_flush();
        cycle(1, 32'h0000_2000, 32'h2442_0001, 8'h01, 0, 0);
        cycle(1, 32'h0000_2004, 32'h2442_0002, 8'h02, 0, 0);
        cycle(1, 32'h0000_2008, 32'h2442_0003, 8'h03, 0, 0);
        cycle(1, 32'h0000_200C, 32'h2442_0004, 8'h04, 0, 0);
        cycle(1, 32'h0000_2010, 32'h1400_0002, 8'h05, 0, 0);
        n_tests++;
        if (qi.count !== 4'd5) begin
            n_fail++;
            $display("FAIL flush_pre: got cnt=%0d want 5", qi.count);
        end
        cycle(1, 32'h0000_2014, 32'h2442_0005, 8'h06, 2, 1);
        n_tests++;
        if (qi.count !== 4'd0 || qi.out_valid !== 2'b00 || qi.out_pc !== 64'd0 || qi.out_inst !== 64'd0 ||
            qi.out_excode !== 16'd0 || qi.out_in_slot !== 2'b00 || qi.out_is_branch !== 2'b00) begin
            n_fail++;
            $display("FAIL flush: got cnt=%0d vld=%b pc=%h inst=%h exc=%h want all 0",
                     qi.count, qi.out_valid, qi.out_pc, qi.out_inst, qi.out_excode);
        end
        cycle(1, 32'h0000_3000, 32'h2442_0007, 8'h07, 0, 0);
        n_tests++;
        if (qi.out_in_slot[0] !== 1'b0 || qi.out_valid !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_last_br: got ds=%b vld=%b want 0 01", qi.out_in_slot[0], qi.out_valid);
        end
        cycle(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] tbl [8] = '{32'h2442_0001, 32'h1000_0003, 32'h03E0_0008, 32'h0C00_0010,
                                 32'h0401_0003, 32'h0410_0002, 32'h0402_0001, 32'h0000_0000};
        logic [31:0] pc = 32'h0000_4000;
        for (int i = 0; i < 60; i++) begin
            cycle($urandom_range(0, 3) != 0, pc, tbl[$urandom_range(0, 7)], 8'(i),
                  $urandom_range(0, 3), 0);
            pc += 4;
        end
        while (sb.size() != 0) cycle(0, 0, 0, 0, 3, 0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) cycle(1, 32'h0000_5000 + 32'(4 * i), 32'h2442_0001, 8'(i + 1), 0, 0);
        n_tests++;
        if (qi.count !== 4'd6) begin
            n_fail++;
            $display("FAIL areset_pre: got cnt=%0d want 6", qi.count);
        end
        #2;
        qi.in_valid = 1'b1;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (qi.count !== 4'd0 || qi.out_valid !== 2'b00 || qi.out_pc !== 64'd0 || qi.out_excode !== 16'd0) begin
            n_fail++;
            $display("FAIL areset: got cnt=%0d vld=%b pc=%h want 0 00 0", qi.count, qi.out_valid, qi.out_pc);
        end
        sb.delete();
        last_br = 1'b0;
        @(negedge clk);
        qi.in_valid = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        n_tests++;
        if (qi.in_ready !== 1'b1 || qi.count !== 4'd0) begin
            n_fail++;
            $display("FAIL areset_release: got rdy=%b cnt=%0d want 1 0", qi.in_ready, qi.count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_branch_pair();
        test_jr_block();
        test_full_wrap();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_inst_queue.md
Name: decode_inst_queue

Overview:
Parametrised instruction queue between fetch and decode. Predecodes branch/jump instructions, tags delay-slot instructions, and presents up to ISSUE_W head entries per cycle to a single- or dual-issue decode stage. It replaces the direct fetch-to-decode pc/instruction register and adds buffering, flush, and issue-pairing rules.

Parameters:
DEPTH, 8, number of entries; power of 2, minimum 4.
ISSUE_W, 2, maximum entries issued per cycle; legal values 1 or 2.
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
flush  input  1  discards all entries (exception, eret, mispredict)
in_valid  input  1  fetch presents an instruction
in_ready  output  1  queue can accept; equals count != DEPTH
in_pc  input  32  pc of the instruction
in_inst  input  32  instruction word
in_excode  input  8  fetch exception bits, stored unchanged
out_valid  output  ISSUE_W  per-slot valid; slot 0 is the oldest entry
out_pc  output  32*ISSUE_W  slot i occupies bits [32i+31:32i]
out_inst  output  32*ISSUE_W  instruction per slot
out_excode  output  8*ISSUE_W  exception bits per slot
out_in_slot  output  ISSUE_W  entry is a branch delay slot
out_is_branch  output  ISSUE_W  entry is a branch or jump (predecoded)
deq_cnt  input  $clog2(ISSUE_W+1)  number of slots consumed this cycle
count  output  CNT_W  current occupancy

Behaviour:
- Reset (asynchronous, resetn=0): head=0, tail=0, count=0, last_br=0. All out_* = 0. in_ready=1 once reset is applied.
- Enqueue fires on a rising edge when in_valid & in_ready. The entry stores pc, inst, excode, is_branch and in_slot=last_br. After the write, last_br takes the new entry's is_branch.
- Predecode sets is_branch=1 for:
  - op=000000 with funct 001000 (JR) or 001001 (JALR);
  - op 000010, 000011, 000100, 000101, 000110, 000111;
  - op=000001 with rt in {00000, 00001, 10000, 10001}.
  - Any other encoding gives 0.
- Latency: an entry written at edge N appears at out slot 0 (if the queue was empty) after edge N. There is no same-cycle bypass.
- Outputs are combinational from head, head+1 (modulo DEPTH). Fields of an invalid slot are driven 0.
- out_valid[0] = (count >= 1).
- out_valid[1] (ISSUE_W=2 only) = (count >= 2) & ~is_branch[head+1]. A branch may only issue in slot 0, so it is never split from its delay slot across a dual-issue boundary. Branch in slot 0 plus its delay slot in slot 1 is allowed.
- Dequeue on an edge removes eff = min(deq_cnt, popcount(out_valid)) entries. head advances by eff, modulo DEPTH. Excess deq_cnt is silently clamped.
- Simultaneous enqueue and dequeue: count_next = count + enq - eff. in_ready depends only on the current count. When full, no enqueue occurs even if a dequeue happens that cycle.
- Pointer wrap: head and tail are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count only.
- flush (synchronous, sampled on the edge) takes priority over enqueue and dequeue in the same cycle: head=tail=0, count=0, last_br=0. The in_inst presented that cycle is dropped.
- Reset asserted mid-operation clears everything asynchronously, regardless of flush or in_valid.
- No state machine beyond the pointers, count, and the last_br flag.

Test Plan:
1. Reset, then enqueue pc=BFC00000 inst=3C080001 (LUI). Next cycle: out_valid=01, out_pc[31:0]=BFC00000, out_is_branch=00, out_in_slot=00, count=1.
2. Enqueue BEQ (10000003) at BFC00000, then ADDIU at BFC00004, with deq_cnt=0. Expect out_valid=11, out_is_branch=01, out_in_slot=10. Apply deq_cnt=2: count drops 2->0.
3. Queue holds ADDU, then JR (03E00008). Expect out_valid=01 (JR blocked from slot 1). deq_cnt=2 removes only 1 entry. Next cycle JR sits in slot 0 with out_valid[0]=1.
4. Fill DEPTH=8 entries with deq_cnt=0: in_ready=0 at count=8, and a 9th in_valid is not accepted. Then dequeue 2 and enqueue 1 per cycle for 20 cycles. Check FIFO order across the pointer wrap via pc sequence +4.
5. With count=5, assert flush together with in_valid=1 and deq_cnt=2. Next cycle: count=0, out_valid=00, all out fields 0. The next enqueued entry after a prior branch has in_slot=0.
6. Drop resetn asynchronously mid-cycle with count=6. Outputs go 0 immediately without a clock edge. After release, in_ready=1 and count=0.
